// File: rtl/uart_alu_packet_engine.sv
// Framed ALU packet engine between UART RX and UART TX: echo, add, sub.
// Defining ALU_MUL_EN adds opcode 0xA2 with a 32-cycle shift-add multiply.
module uart_alu_packet_engine #(
    parameter int DATA_WIDTH_P = 8,
    parameter int OPND_WIDTH_P = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH_P-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH_P-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    err_o,
    output logic                    busy_o
);

    localparam int NB = OPND_WIDTH_P / 8;
    localparam logic [7:0] LAST_BYTE = 8'(NB - 1);
    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_SUB  = 8'hA1;
`ifdef ALU_MUL_EN
    localparam logic [7:0] OP_MUL  = 8'hA2;
    localparam logic [7:0] MUL_LAST = 8'(OPND_WIDTH_P - 1);
`endif

    typedef enum logic [3:0] {
        ST_OPCODE,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_ECHO,
        ST_OPND,
        ST_RESP,
        ST_DRAIN
`ifdef ALU_MUL_EN
        , ST_MUL_BUSY
`endif
    } state_t;

    function automatic logic is_alu(input logic [7:0] op);
        logic r;
        case (op)
            OP_ADD:  r = 1'b1;
            OP_SUB:  r = 1'b1;
`ifdef ALU_MUL_EN
            OP_MUL:  r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic len_ok(input logic [15:0] len);
        logic [15:0] payload;
        payload = len - 16'd4;
        return (payload % 16'(NB)) == 16'd0;
    endfunction

    state_t                    state_r;
    logic                      run_r;
    logic                      err_r;
    logic [7:0]                opcode_r;
    logic [7:0]                len_lo_r;
    logic [15:0]               len_r;
    logic [15:0]               cnt_r;
    logic [OPND_WIDTH_P-9:0]   opnd_r;
    logic [OPND_WIDTH_P-1:0]   acc_r;
    logic                      first_r;
    logic [7:0]                opnd_idx_r;
    logic [7:0]                resp_idx_r;
`ifdef ALU_MUL_EN
    logic [OPND_WIDTH_P-1:0]   mul_opnd_r;
    logic [OPND_WIDTH_P-1:0]   prod_r;
    logic [7:0]                mul_cnt_r;
    logic                      mul_last_r;
    logic [OPND_WIDTH_P-1:0]   mul_sum_s;
`endif

    logic                      s_ready_s;
    logic                      s_hs_s;
    logic                      m_hs_s;
    logic [15:0]               cnt_inc_s;
    logic                      last_s;
    logic [15:0]               len_full_s;
    logic [OPND_WIDTH_P-1:0]   opnd_full_s;

    // Input-side readiness per state; run_r keeps ready low until the first cycle out of reset.
    always_comb begin
        s_ready_s = 1'b0;
        case (state_r)
            ST_OPCODE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_OPND, ST_DRAIN:
                s_ready_s = run_r;
            ST_ECHO: s_ready_s = m_axis_tready;
            default: s_ready_s = 1'b0;
        endcase
    end

    // Handshakes, byte-count end detection and the assembled operand.
    always_comb begin
        s_hs_s      = s_axis_tvalid & s_ready_s;
        m_hs_s      = m_axis_tvalid & m_axis_tready;
        cnt_inc_s   = cnt_r + 16'd1;
        last_s      = (cnt_inc_s == len_r);
        len_full_s  = {s_axis_tdata, len_lo_r};
        opnd_full_s = {s_axis_tdata, opnd_r};
`ifdef ALU_MUL_EN
        if (mul_opnd_r[0]) begin
            mul_sum_s = prod_r + acc_r;
        end else begin
            mul_sum_s = prod_r;
        end
`endif
    end

    // Output stream: zero-latency pass-through while echoing, accumulator bytes while responding.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        if (state_r == ST_ECHO) begin
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tdata  = s_axis_tdata;
        end else if (state_r == ST_RESP) begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = acc_r[{resp_idx_r, 3'b000} +: 8];
        end else begin
            m_axis_tvalid = 1'b0;
            m_axis_tdata  = 8'h00;
        end
    end

    assign s_axis_tready = s_ready_s;
    assign err_o         = err_r;
    assign busy_o        = (state_r != ST_OPCODE);

    // Packet parser, ALU datapath and response sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_OPCODE;
            run_r      <= 1'b0;
            err_r      <= 1'b0;
            opcode_r   <= 8'h00;
            len_lo_r   <= 8'h00;
            len_r      <= 16'd0;
            cnt_r      <= 16'd0;
            opnd_r     <= '0;
            acc_r      <= '0;
            first_r    <= 1'b0;
            opnd_idx_r <= 8'd0;
            resp_idx_r <= 8'd0;
`ifdef ALU_MUL_EN
            mul_opnd_r <= '0;
            prod_r     <= '0;
            mul_cnt_r  <= 8'd0;
            mul_last_r <= 1'b0;
`endif
        end else begin
            run_r <= 1'b1;
            err_r <= 1'b0;
            case (state_r)
                ST_OPCODE: begin
                    if (s_hs_s) begin
                        opcode_r <= s_axis_tdata;
                        cnt_r    <= 16'd1;
                        state_r  <= ST_RSVD;
                    end
                end
                ST_RSVD: begin
                    if (s_hs_s) begin
                        cnt_r   <= cnt_inc_s;
                        state_r <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (s_hs_s) begin
                        len_lo_r <= s_axis_tdata;
                        cnt_r    <= cnt_inc_s;
                        state_r  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (s_hs_s) begin
                        len_r      <= len_full_s;
                        cnt_r      <= cnt_inc_s;
                        opnd_idx_r <= 8'd0;
                        first_r    <= 1'b1;
                        if (len_full_s <= 16'd4) begin
                            state_r <= ST_OPCODE;
                        end else if (opcode_r == OP_ECHO) begin
                            state_r <= ST_ECHO;
                        end else if (!is_alu(opcode_r) || !len_ok(len_full_s)) begin
                            err_r   <= 1'b1;
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_OPND;
                        end
                    end
                end
                ST_ECHO: begin
                    if (s_hs_s) begin
                        cnt_r <= cnt_inc_s;
                        if (last_s) begin
                            state_r <= ST_OPCODE;
                        end
                    end
                end
                ST_OPND: begin
                    if (s_hs_s) begin
                        cnt_r  <= cnt_inc_s;
                        opnd_r <= opnd_full_s[OPND_WIDTH_P-1:8];
                        if (opnd_idx_r == LAST_BYTE) begin
                            opnd_idx_r <= 8'd0;
                            first_r    <= 1'b0;
                            resp_idx_r <= 8'd0;
                            state_r    <= last_s ? ST_RESP : ST_OPND;
                            if (first_r) begin
                                acc_r <= opnd_full_s;
                            end else begin
                                case (opcode_r)
                                    OP_ADD: acc_r <= acc_r + opnd_full_s;
                                    OP_SUB: acc_r <= acc_r - opnd_full_s;
`ifdef ALU_MUL_EN
                                    OP_MUL: begin
                                        mul_opnd_r <= opnd_full_s;
                                        prod_r     <= '0;
                                        mul_cnt_r  <= 8'd0;
                                        mul_last_r <= last_s;
                                        state_r    <= ST_MUL_BUSY;
                                    end
`endif
                                    default: acc_r <= acc_r;
                                endcase
                            end
                        end else begin
                            opnd_idx_r <= opnd_idx_r + 8'd1;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL_BUSY: begin
                    prod_r     <= mul_sum_s;
                    acc_r      <= acc_r << 1;
                    mul_opnd_r <= mul_opnd_r >> 1;
                    mul_cnt_r  <= mul_cnt_r + 8'd1;
                    if (mul_cnt_r == MUL_LAST) begin
                        acc_r      <= mul_sum_s;
                        resp_idx_r <= 8'd0;
                        state_r    <= mul_last_r ? ST_RESP : ST_OPND;
                    end
                end
`endif
                ST_RESP: begin
                    if (m_hs_s) begin
                        if (resp_idx_r == LAST_BYTE) begin
                            state_r <= ST_OPCODE;
                        end else begin
                            resp_idx_r <= resp_idx_r + 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (s_hs_s) begin
                        cnt_r <= cnt_inc_s;
                        if (last_s) begin
                            state_r <= ST_OPCODE;
                        end
                    end
                end
                default: state_r <= ST_OPCODE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_packet_engine.sv
// Directed bench for uart_alu_packet_engine; inputs change 1 ns after posedge, outputs sampled at negedge.
module tb_uart_alu_packet_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       err_o;
    logic       busy_o;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int echo_bad = 0;
    int stall_bad = 0;
    bit echo_mode = 1'b0;
    bit toggle_en = 1'b0;
    logic [7:0] out_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_alu_packet_engine dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: records output handshakes, error pulses and stall stability.
    always @(negedge clk) begin
        if (err_o === 1'b1) err_cnt++;
        if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data)) stall_bad++;
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            out_q.push_back(m_axis_tdata);
            if (echo_mode && !(s_axis_tvalid === 1'b1 && s_axis_tready === 1'b1 && s_axis_tdata === m_axis_tdata))
                echo_bad++;
        end
        prev_stall = (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b0);
        prev_data  = m_axis_tdata;
    end

    always @(posedge clk) begin
        if (toggle_en) begin
            #1 m_axis_tready = ~m_axis_tready;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit done = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (s_axis_tready === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i]);
    endtask

    task automatic wait_out(input int n);
        for (int k = 0; k < 300 && out_q.size() < n; k++) @(posedge clk);
        #1;
        idle(3);
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp[$]);
        check({tag, "_len"}, 32'(out_q.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i < out_q.size()) check(tag, {24'h0, out_q[i]}, {24'h0, exp[i]});
            else check(tag, 32'hDEADBEEF, {24'h0, exp[i]});
        end
        out_q.delete();
    endtask

    int e0;
    int stall_cycles;
    int ready_bad;

    initial begin
        rst_n = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 8'hEC;
        m_axis_tready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", {31'h0, s_axis_tready}, 32'd0);
        check("rst_m_tvalid", {31'h0, m_axis_tvalid}, 32'd0);
        check("rst_m_tdata", {24'h0, m_axis_tdata}, 32'd0);
        check("rst_busy", {31'h0, busy_o}, 32'd0);
        check("rst_err", {31'h0, err_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s_axis_tvalid = 1'b0;
        idle(2);
        check("post_rst_busy", {31'h0, busy_o}, 32'd0);
        out_q.delete();
        err_cnt = 0;

        // Echo, same-cycle pass-through
        echo_mode = 1'b1;
        send_pkt('{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43});
        idle(3);
        echo_mode = 1'b0;
        check_out("echo", '{8'h41, 8'h42, 8'h43});
        check("echo_sync", 32'(echo_bad), 32'd0);
        check("echo_idle_busy", {31'h0, busy_o}, 32'd0);

        // Add with wrap; first response byte valid right after the last operand byte
        send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                   8'hFF, 8'hFF, 8'hFF});
        send(8'hFF);
        check("add_resp_latency", {31'h0, m_axis_tvalid}, 32'd1);
        check("add_resp_byte0", {24'h0, m_axis_tdata}, 32'd0);
        wait_out(4);
        check_out("add", '{8'h00, 8'h00, 8'h00, 8'h00});
        check("add_no_err", 32'(err_cnt), 32'd0);

        // Sub with toggling backpressure
        toggle_en = 1'b1;
        send_pkt('{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00,
                   8'h03, 8'h00, 8'h00, 8'h00});
        wait_out(4);
        toggle_en = 1'b0;
        idle(1);
        m_axis_tready = 1'b1;
        idle(2);
        check_out("sub", '{8'h07, 8'h00, 8'h00, 8'h00});
        check("sub_stall_stable", 32'(stall_bad), 32'd0);

        // Unknown opcode drains, then echo resumes
        e0 = err_cnt;
        send_pkt('{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB,
                   8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A});
        idle(3);
        check("bad_op_err", 32'(err_cnt - e0), 32'd1);
        check_out("bad_op", '{8'h5A});

        // ALU payload not a multiple of 4
        e0 = err_cnt;
        send_pkt('{8'hA0, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22,
                   8'hEC, 8'h00, 8'h05, 8'h00, 8'h77});
        idle(3);
        check("bad_len_err", 32'(err_cnt - e0), 32'd1);
        check_out("bad_len", '{8'h77});

        // len <= 4: header only, silent
        e0 = err_cnt;
        send_pkt('{8'hEC, 8'h00, 8'h04, 8'h00});
        idle(3);
        check("short_no_err", 32'(err_cnt - e0), 32'd0);
        check("short_busy", {31'h0, busy_o}, 32'd0);
        check_out("short", '{});

        // Reset mid-packet discards it
        send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01});
        rst_n = 1'b0;
        idle(2);
        check("midrst_busy", {31'h0, busy_o}, 32'd0);
        rst_n = 1'b1;
        e0 = err_cnt;
        send_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h33});
        idle(3);
        check_out("midrst", '{8'h33});
        check("midrst_no_err", 32'(err_cnt - e0), 32'd0);

        // Multiply
        e0 = err_cnt;
`ifdef ALU_MUL_EN
        send_pkt('{8'hA2, 8'h00, 8'h0C, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00,
                   8'h07, 8'h00, 8'h00, 8'h00});
        stall_cycles = 0;
        ready_bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m_axis_tvalid === 1'b1) break;
            if (s_axis_tready !== 1'b0) ready_bad++;
            stall_cycles++;
        end
        check("mul_busy_cycles", 32'(stall_cycles), 32'd32);
        check("mul_ready_low", 32'(ready_bad), 32'd0);
        wait_out(4);
        check_out("mul", '{8'h2A, 8'h00, 8'h00, 8'h00});
        check("mul_no_err", 32'(err_cnt - e0), 32'd0);
`else
        stall_cycles = 0;
        ready_bad = 0;
        send_pkt('{8'hA2, 8'h00, 8'h0C, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00,
                   8'h07, 8'h00, 8'h00, 8'h00});
        idle(5);
        check("mul_off_err", 32'(err_cnt - e0), 32'd1);
        check("mul_off_busy", {31'h0, busy_o}, 32'd0);
        check_out("mul_off", '{});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
